// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the ID stage and the hazard scoreboard.
// master = pipeline/decode side, slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int REGW  = 5,
  parameter int CNT_W = 16
);
  logic [REGW-1:0]  rs_decode;
  logic [REGW-1:0]  rt_decode;
  logic             use_rs_decode;
  logic             use_rt_decode;
  logic             branch_decode;
  logic [REGW-1:0]  writereg_decode;
  logic             regwrite_decode;
  logic             memtoreg_decode;
  logic             mem_busy;
  logic             stall_fetch;
  logic             stall_decode;
  logic             flush_execute;
  logic             stall_compare;
  logic             forwardA_decode;
  logic             forwardB_decode;
  logic [1:0]       forwardA_execute;
  logic [1:0]       forwardB_execute;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output rs_decode, rt_decode, use_rs_decode, use_rt_decode, branch_decode,
           writereg_decode, regwrite_decode, memtoreg_decode, mem_busy,
    input  stall_fetch, stall_decode, flush_execute, stall_compare,
           forwardA_decode, forwardB_decode, forwardA_execute, forwardB_execute,
           stall_count
  );

  modport slave (
    input  rs_decode, rt_decode, use_rs_decode, use_rt_decode, branch_decode,
           writereg_decode, regwrite_decode, memtoreg_decode, mem_busy,
    output stall_fetch, stall_decode, flush_execute, stall_compare,
           forwardA_decode, forwardB_decode, forwardA_execute, forwardB_execute,
           stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller with an EX/MEM/WB shadow pipeline of destination registers.
// Optional macro STALL_COUNTER_EN adds a saturating hazard-stall counter.
module hazard_scoreboard #(
  parameter int REGW  = 5,
  parameter int CNT_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  hazard_scoreboard_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] dst;
    logic            regwrite;
    logic            memtoreg;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
  } slot_t;

  slot_t r_ex, r_mem, r_wb;
  slot_t w_id_slot;

  function automatic logic f_match(input slot_t s, input logic [REGW-1:0] r);
    return s.valid & s.regwrite & (s.dst == r) & (r != '0);
  endfunction

  logic [REGW-1:0] w_src    [2];
  logic [REGW-1:0] w_ex_src [2];
  logic [1:0]      w_use;
  logic [1:0]      w_ex_hit;
  logic [1:0]      w_mem_hit;
  logic [1:0]      w_fwd_dec;
  logic [1:0]      w_fwd_ex [2];
  logic            w_load_use;
  logic            w_br_haz;
  logic            w_haz;

  assign w_src[0]    = bus.rs_decode;
  assign w_src[1]    = bus.rt_decode;
  assign w_ex_src[0] = r_ex.rs;
  assign w_ex_src[1] = r_ex.rt;
  assign w_use       = {bus.use_rt_decode, bus.use_rs_decode};

  // Index 0 is operand A (rs), index 1 is operand B (rt).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign w_ex_hit[gi]  = w_use[gi] & f_match(r_ex, w_src[gi]);
      assign w_mem_hit[gi] = w_use[gi] & f_match(r_mem, w_src[gi]);
      assign w_fwd_dec[gi] = bus.branch_decode & w_mem_hit[gi] & ~r_mem.memtoreg;
      assign w_fwd_ex[gi]  = (f_match(r_mem, w_ex_src[gi]) & ~r_mem.memtoreg) ? 2'b10 :
                             f_match(r_wb, w_ex_src[gi])                      ? 2'b01 :
                                                                                2'b00;
    end
  endgenerate

  assign w_load_use = r_ex.memtoreg & (|w_ex_hit);
  // Branches compare in ID, so they also wait on an ALU result still in EX and a load in MEM.
  assign w_br_haz   = bus.branch_decode & ((|w_ex_hit) | (r_mem.memtoreg & (|w_mem_hit)));
  assign w_haz      = w_load_use | w_br_haz;

  assign bus.stall_fetch      = w_haz | bus.mem_busy;
  assign bus.stall_decode     = w_haz | bus.mem_busy;
  assign bus.flush_execute    = w_haz & ~bus.mem_busy;
  assign bus.stall_compare    = w_br_haz;
  assign bus.forwardA_decode  = w_fwd_dec[0];
  assign bus.forwardB_decode  = w_fwd_dec[1];
  assign bus.forwardA_execute = w_fwd_ex[0];
  assign bus.forwardB_execute = w_fwd_ex[1];

  assign w_id_slot = '{
    valid:    1'b1,
    dst:      bus.writereg_decode,
    regwrite: bus.regwrite_decode,
    memtoreg: bus.memtoreg_decode,
    rs:       bus.rs_decode,
    rt:       bus.rt_decode
  };

  // Bubbles are fully zeroed so a bubble in EX never selects a forward path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!bus.mem_busy) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_haz ? '0 : w_id_slot;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] r_stall_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= '0;
    end else if (w_haz && !bus.mem_busy && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_count = r_stall_count;
`else
  assign bus.stall_count = {CNT_W{1'b0}};
`endif

  // Operand fields travel with every slot but only EX's are consumed.
  logic w_unused;
  assign w_unused = ^{r_mem.rs, r_mem.rt, r_wb.rs, r_wb.rt, r_wb.memtoreg};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus a
// randomized stream checked against an in-flight instruction list model.
module tb_hazard_scoreboard;
  localparam int REGW = 5;
  localparam int CW   = 4;
`ifdef STALL_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef struct packed {
    bit       v;
    bit [4:0] dst;
    bit       rw;
    bit       m2r;
    bit [4:0] rs;
    bit [4:0] rt;
  } ins_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if #(.REGW(REGW), .CNT_W(CW)) bus ();

  hazard_scoreboard #(.REGW(REGW), .CNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // {stall_fetch, stall_decode, flush_execute, stall_compare, fwdA_dec, fwdB_dec, fwdA_ex, fwdB_ex}
  function automatic logic [9:0] outs();
    return {bus.stall_fetch, bus.stall_decode, bus.flush_execute, bus.stall_compare,
            bus.forwardA_decode, bus.forwardB_decode, bus.forwardA_execute, bus.forwardB_execute};
  endfunction

  task automatic set_id(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                        input bit br, input bit [4:0] wr, input bit rw, input bit m2r,
                        input bit mb);
    bus.rs_decode       = rs;
    bus.rt_decode       = rt;
    bus.use_rs_decode   = urs;
    bus.use_rt_decode   = urt;
    bus.branch_decode   = br;
    bus.writereg_decode = wr;
    bus.regwrite_decode = rw;
    bus.memtoreg_decode = m2r;
    bus.mem_busy        = mb;
    #2;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nop();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [9:0] o;
    rst_n = 1'b0;
    nop();
    o = outs();
    total++;
    if (o !== 10'b0) begin bad++; $display("FAIL reset_outs: got %b expected %b", o, 10'b0); end
    total++;
    if (bus.stall_count !== '0) begin bad++; $display("FAIL reset_count: got %0d expected 0", bus.stall_count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // lw $2 then dependent add, then reset lands mid-stall
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    o = outs();
    total++;
    if (o !== 10'b1110000000) begin bad++; $display("FAIL pre_reset_stall: got %b expected %b", o, 10'b1110000000); end
    rst_n = 1'b0;
    #1;
    o = outs();
    total++;
    if (o !== 10'b0) begin bad++; $display("FAIL reset_mid_stall: got %b expected %b", o, 10'b0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    o = outs();
    total++;
    if (o !== 10'b0) begin bad++; $display("FAIL slots_cleared: got %b expected %b", o, 10'b0); end
    tick();
  endtask

  task automatic test_load_use();
    logic [9:0] o;
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    o = outs();
    total++;
    if (o !== 10'b1110000000) begin bad++; $display("FAIL lu_stall: got %b expected %b", o, 10'b1110000000); end
    tick();
    o = outs();
    total++;
    if (o !== 10'b0) begin bad++; $display("FAIL lu_release: got %b expected %b", o, 10'b0); end
    tick();
    nop();
    o = outs();
    total++;
    if (o !== 10'b0000000100) begin bad++; $display("FAIL lu_fwd_wb: got %b expected %b", o, 10'b0000000100); end
    tick();
  endtask

  task automatic test_alu_branch();
    logic [9:0] o;
    do_reset();
    set_id(5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    o = outs();
    total++;
    if (o !== 10'b1111000000) begin bad++; $display("FAIL alubr_stall: got %b expected %b", o, 10'b1111000000); end
    tick();
    o = outs();
    total++;
    if (o !== 10'b0000100000) begin bad++; $display("FAIL alubr_fwd_dec: got %b expected %b", o, 10'b0000100000); end
    tick();
  endtask

  task automatic test_load_branch();
    logic [9:0] o;
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      o = outs();
      total++;
      if (o !== 10'b1111000000) begin bad++; $display("FAIL ldbr_stall%0d: got %b expected %b", c, o, 10'b1111000000); end
      tick();
    end
    o = outs();
    total++;
    if (o !== 10'b0) begin bad++; $display("FAIL ldbr_regfile: got %b expected %b", o, 10'b0); end
    tick();
  endtask

  task automatic test_zero_and_youngest();
    logic [9:0] o;
    do_reset();
    set_id(5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    o = outs();
    total++;
    if (o !== 10'b0) begin bad++; $display("FAIL zero_nostall: got %b expected %b", o, 10'b0); end
    tick();
    set_id(5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    o = outs();
    total++;
    if (o !== 10'b0) begin bad++; $display("FAIL zero_fwd: got %b expected %b", o, 10'b0); end
    tick();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    o = outs();
    total++;
    if (o !== 10'b0) begin bad++; $display("FAIL alu_nostall: got %b expected %b", o, 10'b0); end
    tick();
    nop();
    o = outs();
    total++;
    if (o !== 10'b0000001010) begin bad++; $display("FAIL youngest_wins: got %b expected %b", o, 10'b0000001010); end
    tick();
  endtask

  task automatic test_mem_busy();
    logic [9:0]    o;
    logic [CW-1:0] exp_cnt;
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      set_id(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
      o = outs();
      total++;
      if (o !== 10'b1100000000) begin bad++; $display("FAIL busy_freeze%0d: got %b expected %b", c, o, 10'b1100000000); end
      total++;
      if (bus.stall_count !== '0) begin bad++; $display("FAIL busy_count%0d: got %0d expected 0", c, bus.stall_count); end
      if (c < 3) tick();
    end
    set_id(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    o = outs();
    total++;
    if (o !== 10'b1110000000) begin bad++; $display("FAIL busy_release: got %b expected %b", o, 10'b1110000000); end
    tick();
    exp_cnt = CNT_ON ? 1 : 0;
    o = outs();
    total++;
    if (o !== 10'b0) begin bad++; $display("FAIL busy_after: got %b expected %b", o, 10'b0); end
    total++;
    if (bus.stall_count !== exp_cnt) begin bad++; $display("FAIL busy_count_inc: got %0d expected %0d", bus.stall_count, exp_cnt); end
    tick();
    for (int k = 0; k < 20; k++) begin
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
    end
    nop();
    exp_cnt = CNT_ON ? CNT_MAX : '0;
    total++;
    if (bus.stall_count !== exp_cnt) begin bad++; $display("FAIL count_saturate: got %0d expected %0d", bus.stall_count, exp_cnt); end
    tick();
  endtask

  function automatic bit prod(input ins_t s, input bit [4:0] r);
    return s.v && s.rw && (s.dst == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_ex(input ins_t ex, input ins_t mem, input ins_t wb,
                                        input bit [4:0] r);
    if (!ex.v) return 2'b00;
    if (prod(mem, r) && !mem.m2r) return 2'b10;
    if (prod(wb, r)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_random();
    ins_t          pipe[$];
    ins_t          ex, mem, wb, nw;
    logic [CW-1:0] cnt;
    logic [9:0]    o, e;
    bit [4:0]      rs, rt, wr;
    bit            urs, urt, br, rw, m2r, mb, lu, bh, haz, dep_ex, dep_mem;
    do_reset();
    pipe = {ins_t'(0), ins_t'(0), ins_t'(0)};
    cnt  = '0;
    for (int n = 0; n < 400; n++) begin
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      wr  = 5'($urandom_range(0, 3));
      urs = 1'($urandom_range(0, 1));
      urt = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 3) == 0);
      rw  = ($urandom_range(0, 3) != 0);
      m2r = rw && ($urandom_range(0, 2) == 0);
      mb  = ($urandom_range(0, 5) == 0);
      set_id(rs, rt, urs, urt, br, wr, rw, m2r, mb);
      ex = pipe[0]; mem = pipe[1]; wb = pipe[2];
      dep_ex  = (urs && prod(ex, rs)) || (urt && prod(ex, rt));
      dep_mem = (urs && prod(mem, rs)) || (urt && prod(mem, rt));
      lu  = ex.m2r && dep_ex;
      bh  = br && (dep_ex || (mem.m2r && dep_mem));
      haz = lu || bh;
      e = {haz || mb, haz || mb, haz && !mb, bh,
           br && urs && prod(mem, rs) && !mem.m2r,
           br && urt && prod(mem, rt) && !mem.m2r,
           fwd_ex(ex, mem, wb, ex.rs), fwd_ex(ex, mem, wb, ex.rt)};
      o = outs();
      total++;
      if (o !== e) begin bad++; $display("FAIL rand_outs[%0d]: got %b expected %b", n, o, e); end
      total++;
      if (bus.stall_count !== (CNT_ON ? cnt : '0))
        begin bad++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, bus.stall_count, CNT_ON ? cnt : '0); end
      if (!mb) begin
        nw = haz ? ins_t'(0) : '{v: 1'b1, dst: wr, rw: rw, m2r: m2r, rs: rs, rt: rt};
        pipe.push_front(nw);
        void'(pipe.pop_back());
        if (haz && cnt != CNT_MAX) cnt = cnt + 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_branch();
    test_load_branch();
    test_zero_and_youngest();
    test_mem_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
